// File: rtl/bus_source_mux.sv
// Registered read-side bus driver: encodes one-hot source strobes, captures the chosen word,
// flags multi-driver conflicts and counts transfers. Define BUS_PRIORITY_EN for lowest-index-wins arbitration.
module bus_source_mux #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_SRC    = 8,
  parameter int unsigned SEL_WIDTH  = 3,
  parameter logic [DATA_WIDTH-1:0] IDLE_VALUE = '0
) (
  input  logic                          clock,
  input  logic                          clear,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
  input  logic [NUM_SRC-1:0]            src_out,
  input  logic                          conflict_ack,
  output logic [DATA_WIDTH-1:0]         BusMuxOut,
  output logic                          bus_valid,
  output logic [SEL_WIDTH-1:0]          bus_sel,
  output logic                          conflict,
  output logic [15:0]                   xfer_count
);

  localparam int unsigned CNT_WIDTH = 16;

`ifdef BUS_PRIORITY_EN
  localparam bit PRIORITY_EN = 1'b1;
`else
  localparam bit PRIORITY_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DRIVE    = 2'd1,
    CONFLICT = 2'd2
  } state_t;

  state_t                state;
  logic                  any_c;
  logic                  multi_c;
  logic                  take_c;
  logic [SEL_WIDTH-1:0]  low_idx_c;
  logic [DATA_WIDTH-1:0] sel_word_c;

  // Lowest asserted source and its word; with a single strobe this is the only source.
  always_comb begin
    low_idx_c  = '0;
    sel_word_c = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (src_out[i]) begin
        low_idx_c  = SEL_WIDTH'(i);
        sel_word_c = src_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    any_c   = |src_out;
    multi_c = |(src_out & (src_out - NUM_SRC'(1)));
    take_c  = any_c && (!multi_c || PRIORITY_EN);
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state      <= IDLE;
      BusMuxOut  <= IDLE_VALUE;
      bus_valid  <= 1'b0;
      bus_sel    <= '0;
      conflict   <= 1'b0;
      xfer_count <= '0;
    end else begin
      case (state)
        IDLE, DRIVE: begin
          bus_valid <= 1'b0;
          // Ack in a non-conflict state only matters when priority mode left the flag set.
          if (PRIORITY_EN && conflict_ack) conflict <= 1'b0;
          if (multi_c) conflict <= 1'b1;
          if (take_c) begin
            BusMuxOut  <= sel_word_c;
            bus_sel    <= low_idx_c;
            bus_valid  <= 1'b1;
            xfer_count <= xfer_count + CNT_WIDTH'(1);
            state      <= DRIVE;
          end else if (multi_c) begin
            state <= CONFLICT;
          end else begin
            state <= IDLE;
          end
        end
        CONFLICT: begin
          bus_valid <= 1'b0;
          if (conflict_ack) begin
            conflict <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          bus_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_source_mux.sv
// Scoreboard bench for bus_source_mux: a behavioural model queues expected outputs per cycle.
module tb_bus_source_mux;

  logic         clock = 1'b0;
  logic         clear;
  logic [255:0] src_data;
  logic [7:0]   src_out;
  logic         conflict_ack;
  logic [31:0]  BusMuxOut;
  logic         bus_valid;
  logic [2:0]   bus_sel;
  logic         conflict;
  logic [15:0]  xfer_count;

  bus_source_mux dut (
    .clock(clock), .clear(clear), .src_data(src_data), .src_out(src_out),
    .conflict_ack(conflict_ack), .BusMuxOut(BusMuxOut), .bus_valid(bus_valid),
    .bus_sel(bus_sel), .conflict(conflict), .xfer_count(xfer_count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] out;
    logic        valid;
    logic [2:0]  sel;
    logic        conf;
    logic [15:0] cnt;
  } obs_t;

  obs_t        q[$];
  logic [31:0] word[8];
  int          tests = 0;
  int          failed = 0;

  // Reference model state (0 idle, 1 drive, 2 conflict)
  obs_t m;
  int   m_state;

  function automatic obs_t sample();
    obs_t o;
    o.out = BusMuxOut; o.valid = bus_valid; o.sel = bus_sel;
    o.conf = conflict; o.cnt = xfer_count;
    return o;
  endfunction

  task automatic model(input logic [7:0] so, input logic ack, input logic clr);
    int n = 0;
    int k = -1;
    for (int i = 0; i < 8; i++) if (so[i]) begin n++; if (k < 0) k = i; end
    if (clr) begin
      m = '0; m_state = 0;
    end else if (m_state == 2) begin
      m.valid = 1'b0;
      if (ack) begin m.conf = 1'b0; m_state = 0; end
    end else begin
`ifdef BUS_PRIORITY_EN
      if (ack) m.conf = 1'b0;
      if (n >= 2) m.conf = 1'b1;
      if (n >= 1) begin
        m.out = word[k]; m.sel = 3'(k); m.valid = 1'b1; m.cnt = m.cnt + 16'd1; m_state = 1;
      end else begin
        m.valid = 1'b0; m_state = 0;
      end
`else
      if (n == 1) begin
        m.out = word[k]; m.sel = 3'(k); m.valid = 1'b1; m.cnt = m.cnt + 16'd1; m_state = 1;
      end else if (n == 0) begin
        m.valid = 1'b0; m_state = 0;
      end else begin
        m.valid = 1'b0; m.conf = 1'b1; m_state = 2;
      end
`endif
    end
  endtask

  // Drive one cycle of stimulus, queue the model's prediction, and return #1 after the edge.
  task automatic step(input logic [7:0] so, input logic ack, input logic clr);
    for (int i = 0; i < 8; i++) src_data[i*32 +: 32] = word[i];
    src_out = so; conflict_ack = ack; clear = clr;
    model(so, ack, clr);
    q.push_back(m);
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    obs_t got, exp;
    word[0] = 32'h1234_5678;
    for (int c = 0; c < 2; c++) begin
      step(8'h01, 1'b0, 1'b1);
      got = sample(); exp = q.pop_front(); tests++;
      if (got !== exp) begin failed++; $display("FAIL reset: got %h exp %h", got, exp); end
    end
    tests++;
    if ({BusMuxOut, bus_valid, bus_sel, conflict, xfer_count} !== 53'd0) begin
      failed++; $display("FAIL reset_values: got %h exp 0", {BusMuxOut, bus_valid, bus_sel, conflict, xfer_count});
    end
  endtask

  task automatic test_single();
    obs_t got, exp;
    word[3] = 32'hDEAD_BEEF;
    step(8'h08, 1'b0, 1'b0);
    got = sample(); exp = q.pop_front(); tests++;
    if (got !== exp) begin failed++; $display("FAIL single: got %h exp %h", got, exp); end
    tests++;
    if (BusMuxOut !== 32'hDEAD_BEEF || bus_sel !== 3'd3 || bus_valid !== 1'b1 || xfer_count !== 16'd1) begin
      failed++; $display("FAIL single_const: got out=%h sel=%0d v=%b cnt=%0d exp out=deadbeef sel=3 v=1 cnt=1",
                         BusMuxOut, bus_sel, bus_valid, xfer_count);
    end
    step(8'h00, 1'b0, 1'b0);
    got = sample(); exp = q.pop_front(); tests++;
    if (got !== exp) begin failed++; $display("FAIL single_hold: got %h exp %h", got, exp); end
    tests++;
    if (bus_valid !== 1'b0 || BusMuxOut !== 32'hDEAD_BEEF) begin
      failed++; $display("FAIL single_hold_const: got v=%b out=%h exp v=0 out=deadbeef", bus_valid, BusMuxOut);
    end
  endtask

  task automatic test_back_to_back();
    obs_t got, exp;
    logic [7:0] pat[2] = '{8'h01, 8'h80};
    word[0] = 32'd1; word[7] = 32'd7;
    for (int c = 0; c < 2; c++) begin
      step(pat[c], 1'b0, 1'b0);
      got = sample(); exp = q.pop_front(); tests++;
      if (got !== exp) begin failed++; $display("FAIL back_to_back[%0d]: got %h exp %h", c, got, exp); end
    end
    tests++;
    if (BusMuxOut !== 32'd7 || bus_sel !== 3'd7 || bus_valid !== 1'b1 || xfer_count !== 16'd3) begin
      failed++; $display("FAIL back_to_back_const: got out=%h sel=%0d v=%b cnt=%0d exp 7/7/1/3",
                         BusMuxOut, bus_sel, bus_valid, xfer_count);
    end
  endtask

  task automatic test_conflict();
    obs_t got, exp;
    logic [7:0] pat[5] = '{8'h05, 8'h01, 8'h00, 8'h00, 8'h01};
    logic       ack[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    word[0] = 32'h0000_00A0; word[2] = 32'h0000_00C2;
    for (int c = 0; c < 5; c++) begin
      step(pat[c], ack[c], 1'b0);
      got = sample(); exp = q.pop_front(); tests++;
      if (got !== exp) begin failed++; $display("FAIL conflict[%0d]: got %h exp %h", c, got, exp); end
      if (c == 0) begin
        tests++;
        if (conflict !== 1'b1) begin failed++; $display("FAIL conflict_set: got %b exp 1", conflict); end
      end
    end
  endtask

  task automatic test_ack_outside();
    obs_t got, exp;
    step(8'h00, 1'b1, 1'b0);
    got = sample(); exp = q.pop_front(); tests++;
    if (got !== exp) begin failed++; $display("FAIL ack_outside: got %h exp %h", got, exp); end
  endtask

`ifdef BUS_PRIORITY_EN
  task automatic test_priority();
    obs_t got, exp;
    word[1] = 32'hAAAA_0001; word[2] = 32'hBBBB_0002;
    step(8'h06, 1'b0, 1'b0);
    got = sample(); exp = q.pop_front(); tests++;
    if (got !== exp) begin failed++; $display("FAIL priority: got %h exp %h", got, exp); end
    tests++;
    if (BusMuxOut !== 32'hAAAA_0001 || bus_sel !== 3'd1 || bus_valid !== 1'b1 || conflict !== 1'b1) begin
      failed++; $display("FAIL priority_const: got out=%h sel=%0d v=%b c=%b exp aaaa0001/1/1/1",
                         BusMuxOut, bus_sel, bus_valid, conflict);
    end
    step(8'h00, 1'b1, 1'b0);
    got = sample(); exp = q.pop_front(); tests++;
    if (got !== exp) begin failed++; $display("FAIL priority_ack: got %h exp %h", got, exp); end
  endtask
`endif

  task automatic test_random();
    obs_t got, exp;
    logic [7:0] so;
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < 8; i++) word[i] = $urandom;
      case ($urandom_range(0, 3))
        0: so = 8'h00;
        3: begin
          int a = $urandom_range(0, 7);
          int b = (a + $urandom_range(1, 7)) % 8;
          so = 8'(1 << a) | 8'(1 << b) | 8'($urandom);
        end
        default: so = 8'(1 << $urandom_range(0, 7));
      endcase
      step(so, ($urandom_range(0, 3) == 0), 1'b0);
      got = sample(); exp = q.pop_front(); tests++;
      if (got !== exp) begin failed++; $display("FAIL random[%0d]: got %h exp %h", c, got, exp); end
    end
  endtask

  task automatic test_wrap_and_clear();
    obs_t got, exp;
    step(8'h00, 1'b0, 1'b1);
    void'(q.pop_front());
    word[0] = 32'h0000_0F0F;
    for (int i = 0; i < 8; i++) src_data[i*32 +: 32] = word[i];
    src_out = 8'h01; conflict_ack = 1'b0; clear = 1'b0;
    repeat (65535) @(posedge clock);
    #1;
    m.out = 32'h0000_0F0F; m.sel = 3'd0; m.valid = 1'b1; m.conf = 1'b0; m.cnt = 16'hFFFF; m_state = 1;
    tests++;
    if (xfer_count !== 16'hFFFF) begin failed++; $display("FAIL preload: got %h exp ffff", xfer_count); end
    step(8'h01, 1'b0, 1'b0);
    got = sample(); exp = q.pop_front(); tests++;
    if (got !== exp || xfer_count !== 16'h0000) begin
      failed++; $display("FAIL wrap: got %h exp %h", got, exp);
    end
    step(8'h01, 1'b0, 1'b1);
    got = sample(); exp = q.pop_front(); tests++;
    if (got !== exp || BusMuxOut !== 32'd0 || bus_valid !== 1'b0 || xfer_count !== 16'd0) begin
      failed++; $display("FAIL clear_mid: got %h exp %h", got, exp);
    end
    step(8'h01, 1'b0, 1'b0);
    got = sample(); exp = q.pop_front(); tests++;
    if (got !== exp) begin failed++; $display("FAIL after_clear: got %h exp %h", got, exp); end
  endtask

  initial begin
    clear = 1'b1; src_out = '0; conflict_ack = 1'b0; src_data = '0;
    for (int i = 0; i < 8; i++) word[i] = 32'(i);
    m = '0; m_state = 0;
    @(posedge clock);
    #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_conflict();
    test_ack_outside();
`ifdef BUS_PRIORITY_EN
    test_priority();
`endif
    test_random();
    test_wrap_and_clear();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
